// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: accumulates a configurable CRC over a framed stream of
// DATA_W-bit beats (partial final beat allowed) and emits one registered result
// per frame over a valid/ready port.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready beat handshake; in_ready drops only while a result is held
//   in_data           beat, byte 0 in the top byte lane, processed first
//   in_last           final beat of the frame
//   in_nbytes         valid leading bytes on the last beat (0 or too large = full)
//   out_valid/out_ready result handshake
//   out_crc           final CRC of the frame
//   out_len           frame length in bytes, saturating
//   out_len_ovf       frame length exceeded the counter range
`timescale 1ns/1ps
module crc_stream_engine #(
   parameter int unsigned       DATA_W  = 64,
   parameter int unsigned       CRC_W   = 16,
   parameter logic [CRC_W-1:0]  POLY    = 16'h8005,
   parameter logic [CRC_W-1:0]  INIT    = 16'h0000,
   parameter logic [CRC_W-1:0]  XOR_OUT = 16'h0000,
   parameter bit                REFIN   = 1'b0,
   parameter bit                REFOUT  = 1'b0,
   parameter int unsigned       LEN_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        in_last,
   input  logic [$clog2(DATA_W/8):0]   in_nbytes,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CRC_W-1:0]            out_crc,
   output logic [LEN_W-1:0]            out_len,
   output logic                        out_len_ovf
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned NBW   = $clog2(NB) + 1;
   localparam int unsigned SUM_W = ((LEN_W > NBW) ? LEN_W : NBW) + 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q;
   logic [CRC_W-1:0]   crc_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovf_q;

   logic               accept_c;
   logic [NBW-1:0]     nb_eff_c;
   logic [CRC_W-1:0]   crc_next_c;
   logic [CRC_W-1:0]   result_c;
   logic [SUM_W-1:0]   sum_c;
   logic [LEN_W-1:0]   len_next_c;
   logic               ovf_next_c;

   // Stall only while an unconsumed result is held.
   assign in_ready = !(out_valid && !out_ready);
   assign accept_c = in_valid && in_ready;

   // Bytes to process this beat; illegal last-beat counts mean a full beat.
   always_comb begin
      nb_eff_c = NBW'(NB);
      if (in_last && (in_nbytes != '0) && (in_nbytes <= NBW'(NB)))
         nb_eff_c = in_nbytes;
   end

   // Unrolled MSB-first LFSR over the leading nb_eff_c bytes of the beat.
   always_comb begin
      logic [CRC_W-1:0]  crc_v;
      logic [DATA_W-1:0] data_v;
      logic [7:0]        byte_v;
      logic              fb;
      crc_v  = (state_q == IDLE) ? INIT : crc_q;
      data_v = in_data;
      byte_v = '0;
      fb     = 1'b0;
      for (int unsigned i = 0; i < NB; i++) begin
         byte_v = data_v[DATA_W-1 -: 8];
         data_v = data_v << 8;
         if (REFIN)
            byte_v = {<<{byte_v}};
         if (NBW'(i) < nb_eff_c) begin
            for (int unsigned b = 0; b < 8; b++) begin
               fb     = crc_v[CRC_W-1] ^ byte_v[7];
               byte_v = {byte_v[6:0], 1'b0};
               crc_v  = {crc_v[CRC_W-2:0], 1'b0};
               if (fb)
                  crc_v = crc_v ^ POLY;
            end
         end
      end
      crc_next_c = crc_v;
   end

   always_comb begin
      result_c = REFOUT ? {<<{crc_next_c}} : crc_next_c;
      result_c = result_c ^ XOR_OUT;
   end

   // Saturating byte count; a new frame starts counting from zero.
   always_comb begin
      logic [LEN_W-1:0] base_v;
      logic             base_ovf_v;
      base_v     = (state_q == IDLE) ? '0 : len_q;
      base_ovf_v = (state_q == IDLE) ? 1'b0 : ovf_q;
      sum_c      = SUM_W'(base_v) + SUM_W'(nb_eff_c);
      ovf_next_c = base_ovf_v || (sum_c > SUM_W'({LEN_W{1'b1}}));
      len_next_c = ovf_next_c ? {LEN_W{1'b1}} : LEN_W'(sum_c);
   end

   // Frame FSM, running CRC/length state and registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         crc_q       <= INIT;
         len_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid   <= 1'b0;
         out_crc     <= '0;
         out_len     <= '0;
         out_len_ovf <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
            out_crc     <= '0;
            out_len     <= '0;
            out_len_ovf <= 1'b0;
         end
         if (accept_c) begin
            if (in_last) begin
               state_q     <= IDLE;
               crc_q       <= INIT;
               len_q       <= '0;
               ovf_q       <= 1'b0;
               out_valid   <= 1'b1;
               out_crc     <= result_c;
               out_len     <= len_next_c;
               out_len_ovf <= ovf_next_c;
            end else begin
               state_q <= BUSY;
               crc_q   <= crc_next_c;
               len_q   <= len_next_c;
               ovf_q   <= ovf_next_c;
            end
         end
      end
   end

endmodule
